// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD (double-dabble) converter driving active-low 7-segment digits.
// Optional leading-zero blanking: define DISP_LZ_BLANK_EN.
module bcd_display_driver #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [8*DIGITS-1:0] seg
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 8 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned VAL_W = WIDTH + 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Largest displayable value; unreachable bounds disable the overflow flag
  localparam longint unsigned LIMIT   = pow10(DIGITS) - 64'd1;
  localparam bit              REACH   = (LIMIT < (64'd1 << WIDTH));
  localparam logic [VAL_W-1:0] MAX_VAL = REACH ? VAL_W'(LIMIT) : {VAL_W{1'b1}};

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ENCODE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SEG_W-1:0]   seg_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= {SEG_W{1'b1}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
    end
  end

  // Add-3 correction applied to every nibble before each shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Digit patterns from the finished BCD register
  always_comb begin
    seg_enc = {SEG_W{1'b1}};
`ifdef DISP_LZ_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
        if ((bcd_q[4*k +: 4] != 4'd0) || (k == 0)) lead = 1'b0;
        seg_enc[8*k +: 8] = lead ? 8'hFF : seg_of(bcd_q[4*k +: 4]);
      end
    end
`else
    for (int k = 0; k < int'(DIGITS); k++) begin
      seg_enc[8*k +: 8] = seg_of(bcd_q[4*k +: 4]);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    seg_d      = seg_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          ovf_d   = REACH && ({1'b0, value} > MAX_VAL);
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        seg_d      = ovf_q ? {DIGITS{8'hBF}} : seg_enc;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: default 20/6 instance plus 8/3 and 1/1 instances.
module tb_bcd_display_driver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] value;
  logic        busy, done, overflow;
  logic [47:0] seg;

  logic        start_s;
  logic [7:0]  value_s;
  logic        busy_s, done_s, overflow_s;
  logic [23:0] seg_s;

  logic        start_1;
  logic [0:0]  value_1;
  logic        busy_1, done_1, overflow_1;
  logic [7:0]  seg_1;

  int errors = 0;
  int checks = 0;
  int n;
  int pulses;

`ifdef DISP_LZ_BLANK_EN
  localparam logic [47:0] EXP_ZERO  = 48'hFFFF_FFFF_FFC0;
  localparam logic [47:0] EXP_SEVEN = 48'hFFFF_FFFF_FFF8;
  localparam logic [47:0] EXP_42    = 48'hFFFF_FFFF_99A4;
  localparam logic [47:0] EXP_31    = 48'hFFFF_FFFF_B0F9;
`else
  localparam logic [47:0] EXP_ZERO  = 48'hC0C0_C0C0_C0C0;
  localparam logic [47:0] EXP_SEVEN = 48'hC0C0_C0C0_C0F8;
  localparam logic [47:0] EXP_42    = 48'hC0C0_C0C0_99A4;
  localparam logic [47:0] EXP_31    = 48'hC0C0_C0C0_B0F9;
`endif

  bcd_display_driver #(.WIDTH(20), .DIGITS(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg)
  );

  bcd_display_driver #(.WIDTH(8), .DIGITS(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .value(value_s),
    .busy(busy_s), .done(done_s), .overflow(overflow_s), .seg(seg_s)
  );

  bcd_display_driver #(.WIDTH(1), .DIGITS(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_1), .value(value_1),
    .busy(busy_1), .done(done_1), .overflow(overflow_1), .seg(seg_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a conversion on the main instance and wait (bounded) for done
  task automatic convert(input logic [19:0] v);
    int cyc;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!done) chk("busy_during", 64'(busy), 64'd1);
    end
    chk("latency", 64'(cyc), 64'd21);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    value   = '0;
    start_s = 1'b0;
    value_s = '0;
    start_1 = 1'b0;
    value_1 = '0;

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_done_idle", 64'(done), 64'd0);
    end

    convert(20'd123456);
    chk("seg_123456", 64'(seg), 64'hF9A4_B099_9282);
    chk("ovf_123456", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("seg_hold", 64'(seg), 64'hF9A4_B099_9282);

    convert(20'd1000000);
    chk("ovf_1000000", 64'(overflow), 64'd1);
    chk("seg_1000000", 64'(seg), 64'hBFBF_BFBF_BFBF);

    convert(20'd999999);
    chk("ovf_999999", 64'(overflow), 64'd0);
    chk("seg_999999", 64'(seg), 64'h9090_9090_9090);

    convert(20'd0);
    chk("seg_0", 64'(seg), 64'(EXP_ZERO));
    convert(20'd7);
    chk("seg_7", 64'(seg), 64'(EXP_SEVEN));

    // Start while busy is ignored; start in done cycle is accepted
    value = 20'd42;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    value = 20'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_start_done", 64'(done), 64'd1);
    chk("seg_ignore", 64'(seg), 64'(EXP_42));
    value = 20'd31;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == 1) chk("b2b_done_low", 64'(done), 64'd0);
    end while (!done && n < 50);
    chk("b2b_spacing", 64'(n), 64'd22);
    chk("seg_31", 64'(seg), 64'(EXP_31));

    // Reset mid-conversion discards the result
    convert(20'd1000000);
    chk("ovf_pre_rst", 64'(overflow), 64'd1);
    value = 20'd123;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);

    // WIDTH=8, DIGITS=3
    value_s = 8'd255;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    while (!done_s && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small_latency", 64'(n), 64'd9);
    chk("small_seg", 64'(seg_s), 64'hA49292);
    chk("small_ovf", 64'(overflow_s), 64'd0);

    // WIDTH=1, DIGITS=1
    value_1 = 1'b1;
    start_1 = 1'b1;
    @(posedge clk); #1;
    start_1 = 1'b0;
    n = 0;
    while (!done_1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("one_latency", 64'(n), 64'd2);
    chk("one_seg", 64'(seg_1), 64'hF9);
    chk("one_ovf", 64'(overflow_1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
